// File: rtl/pack_pkg.sv
// Shared defaults, lane-count helper and packed word type for the pack_stream lane packer.
package pack_pkg;
    localparam int DEF_IN_W    = 24;
    localparam int DEF_LANE_W  = 8;
    localparam int DEF_LANES   = 4;
    localparam int DEF_SHIFT_W = 5;

    typedef logic [DEF_LANES*DEF_LANE_W-1:0] pack_word_t;

    // Width needed to hold a lane count of 0..lanes inclusive.
    function automatic int lane_cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction
endpackage

// File: rtl/pack_sat.sv
// Combinational arithmetic right shift and signed saturation of one sample into one lane.
// Instantiated by pack_stream only when PACK_SAT_EN is defined.
module pack_sat
    import pack_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic [IN_W-1:0]    in_data,
    input  logic [SHIFT_W-1:0] shift,
    output logic [LANE_W-1:0]  lane,
    output logic               clip
);
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
    // Lane limits sign-extended to the sample width for the range compare.
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-LANE_W){1'b0}}, LANE_MAX};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-LANE_W){1'b1}}, LANE_MIN};

    logic signed [IN_W-1:0] shifted;
    logic                   hi;
    logic                   lo;

    assign shifted = $signed(in_data) >>> shift;
    assign hi      = shifted > MAX_V;
    assign lo      = shifted < MIN_V;
    assign clip    = hi | lo;

    always_comb begin
        if (hi) begin
            lane = LANE_MAX;
        end else if (lo) begin
            lane = LANE_MIN;
        end else begin
            lane = shifted[LANE_W-1:0];
        end
    end
endmodule

// File: rtl/pack_stream.sv
// Packs a valid/ready stream of samples into LANES-lane words with flush and a lane-count tag.
// Build option PACK_SAT_EN: shift+saturate input stage (one extra register) and sat_hit output.
module pack_stream
    import pack_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int LANES   = DEF_LANES,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          flush,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*LANE_W-1:0]       out_data,
    output logic [lane_cnt_w(LANES)-1:0]  out_lanes
`ifdef PACK_SAT_EN
    ,
    output logic                          sat_hit
`endif
);
    localparam int CNT_W  = lane_cnt_w(LANES);
    localparam int WORD_W = LANES * LANE_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_ins;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_ins;
    logic              flush_pend;

    logic              core_valid;
    logic [LANE_W-1:0] core_lane;
    logic              core_flush;
    logic              core_ready;
    logic              core_accept;
    logic              complete;
    logic              out_free;
    logic              flush_req;
    logic              load_part;
    logic              set_pend;
    logic              load;

`ifdef PACK_SAT_EN
    logic [LANE_W-1:0] sat_lane;
    logic              sat_clip;
    logic              s_valid;
    logic              s_flush;
    logic [LANE_W-1:0] s_lane;
    logic              in_accept;

    pack_sat #(
        .IN_W    (IN_W),
        .LANE_W  (LANE_W),
        .SHIFT_W (SHIFT_W)
    ) u_sat (
        .in_data (in_data),
        .shift   (cfg_shift),
        .lane    (sat_lane),
        .clip    (sat_clip)
    );

    assign in_ready  = !s_valid || core_ready;
    assign in_accept = in_valid && in_ready;

    // A flush rides with the staged beat so that beat is always packed before the flush acts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_lane  <= '0;
            s_flush <= 1'b0;
            sat_hit <= 1'b0;
        end else if (clear) begin
            s_valid <= 1'b0;
            s_lane  <= '0;
            s_flush <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            sat_hit <= in_accept && sat_clip;
            if (in_ready) begin
                s_valid <= in_accept;
                s_lane  <= sat_lane;
                s_flush <= flush;
            end else begin
                s_flush <= s_flush || flush;
            end
        end
    end

    assign core_valid = s_valid;
    assign core_lane  = s_lane;
    assign core_flush = s_flush && (!s_valid || core_accept);
`else
    logic unused_bits;

    assign unused_bits = ^{cfg_shift, in_data[IN_W-1:LANE_W]};
    assign core_valid  = in_valid;
    assign core_lane   = in_data[LANE_W-1:0];
    assign core_flush  = flush;
    assign in_ready    = core_ready;
`endif

    assign out_free    = !out_valid || out_ready;
    assign core_ready  = !((cnt == LAST) && out_valid && !out_ready) && !flush_pend;
    assign core_accept = core_valid && core_ready;
    assign complete    = core_accept && (cnt == LAST);
    assign cnt_ins     = cnt + CNT_W'(core_accept);

    always_comb begin
        acc_ins = acc;
        if (core_accept) begin
            acc_ins[int'(cnt)*LANE_W +: LANE_W] = core_lane;
        end
    end

    // A completing beat already emits a full word, so a flush with it has nothing left to do.
    assign flush_req = core_flush && !flush_pend && !complete && (cnt_ins != '0);
    assign load_part = (flush_pend || flush_req) && out_free;
    assign set_pend  = flush_req && !out_free;
    assign load      = complete || load_part;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_lanes  <= '0;
        end else if (clear) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= acc_ins;
            out_lanes  <= cnt_ins;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            out_valid  <= out_valid && !out_ready;
            acc        <= acc_ins;
            cnt        <= cnt_ins;
            if (set_pend) begin
                flush_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pack_stream.sv
// Bench for pack_stream: directed scenarios plus a randomized run scored against a lane-queue model.
module tb_pack_stream;
    import pack_pkg::*;

    localparam int IN_W    = DEF_IN_W;
    localparam int LANE_W  = DEF_LANE_W;
    localparam int LANES   = DEF_LANES;
    localparam int SHIFT_W = DEF_SHIFT_W;
    localparam int CNT_W   = lane_cnt_w(LANES);

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               clear     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               flush     = 1'b0;
    logic               out_ready = 1'b0;
    logic [IN_W-1:0]    in_data   = '0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               in_ready;
    logic               out_valid;
    pack_word_t         out_data;
    logic [CNT_W-1:0]   out_lanes;
`ifdef PACK_SAT_EN
    logic               sat_hit;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [LANE_W-1:0] pend_q[$];
    pack_word_t        exp_d[$];
    int                exp_l[$];
    pack_word_t        got_d[$];
    int                got_l[$];
    bit                hold_v = 1'b0;
    pack_word_t        hold_d;
    logic [CNT_W-1:0]  hold_l;
    pack_word_t        mon_ed;
    int                mon_el;

    pack_stream #(
        .IN_W    (IN_W),
        .LANE_W  (LANE_W),
        .LANES   (LANES),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .cfg_shift (cfg_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lanes (out_lanes)
`ifdef PACK_SAT_EN
        ,
        .sat_hit   (sat_hit)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1);
    end

`ifdef PACK_SAT_EN
    function automatic logic [LANE_W-1:0] ref_sat(input logic [IN_W-1:0] d, input logic [SHIFT_W-1:0] sh);
        int v;
        int hi;
        int lo;
        hi = (1 << (LANE_W - 1)) - 1;
        lo = -(1 << (LANE_W - 1));
        v  = int'($signed(d));
        v  = v >>> sh;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return v[LANE_W-1:0];
    endfunction
`endif

    // Collected lanes become one word: lane i at bits i*LANE_W, unwritten lanes zero.
    function automatic void emit_word();
        pack_word_t w;
        w = '0;
        for (int i = 0; i < pend_q.size(); i++) w[i*LANE_W +: LANE_W] = pend_q[i];
        exp_d.push_back(w);
        exp_l.push_back(pend_q.size());
        pend_q.delete();
    endfunction

    always @(negedge clk) begin
        if (!rst_n || clear) begin
            pend_q.delete();
            exp_d.delete();
            exp_l.delete();
            hold_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (hold_v) begin
                    n_cmp++;
                    if (out_data !== hold_d || out_lanes !== hold_l) begin
                        n_fail++;
                        $display("FAIL hold_stable: data=%h lanes=%0d, required data=%h lanes=%0d",
                                 out_data, out_lanes, hold_d, hold_l);
                    end
                end
                if (out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(int'(out_lanes));
                    hold_v = 1'b0;
                    n_cmp++;
                    if (exp_d.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: data=%h lanes=%0d, required no word", out_data, out_lanes);
                    end else begin
                        mon_ed = exp_d.pop_front();
                        mon_el = exp_l.pop_front();
                        if (out_data !== mon_ed || int'(out_lanes) !== mon_el) begin
                            n_fail++;
                            $display("FAIL word_order: data=%h lanes=%0d, required data=%h lanes=%0d",
                                     out_data, out_lanes, mon_ed, mon_el);
                        end
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                    hold_l = out_lanes;
                end
            end
            if (in_valid && in_ready) begin
`ifdef PACK_SAT_EN
                pend_q.push_back(ref_sat(in_data, cfg_shift));
`else
                pend_q.push_back(in_data[LANE_W-1:0]);
`endif
            end
            if (pend_q.size() == LANES) emit_word();
            if (flush && pend_q.size() > 0) emit_word();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input bit fl, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_d.size() != 0 || out_valid) && t < 300) begin
            tick();
            t++;
        end
        n_cmp++;
        if (exp_d.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL drain_timeout: words left=%0d out_valid=%b, required 0 and 0", exp_d.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_lanes !== '0) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b data=%h lanes=%0d, required 0 0 0", out_valid, out_data, out_lanes);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0 || out_lanes !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: data=%h lanes=%0d, required 0 0", out_data, out_lanes);
        end
    endtask

    task automatic test_full_words();
        int w;
        int base;
        int stalls;
        base      = got_d.size();
        stalls    = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(IN_W'(i), 1'b0, w);
            stalls += w;
        end
        drain();
        n_cmp++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL full_bubbles: stall cycles=%0d, required 0", stalls);
        end
        n_cmp++;
        if (got_d.size() - base !== 2) begin
            n_fail++;
            $display("FAIL full_count: words=%0d, required 2", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h04030201 || got_l[base] !== 4) begin
                n_fail++;
                $display("FAIL full_word0: data=%h lanes=%0d, required 04030201 4", got_d[base], got_l[base]);
            end
            n_cmp++;
            if (got_d[base+1] !== 32'h08070605 || got_l[base+1] !== 4) begin
                n_fail++;
                $display("FAIL full_word1: data=%h lanes=%0d, required 08070605 4", got_d[base+1], got_l[base+1]);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int w;
        int base;
        int t;
        base      = got_d.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(IN_W'(i), 1'b0, w);
`ifndef PACK_SAT_EN
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b with last lane pending, required 0", in_ready);
        end
`endif
        in_valid = 1'b1;
        in_data  = IN_W'(8);
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h, required 1 04030201", out_valid, out_data);
        end
        out_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        n_cmp++;
        if (got_d.size() - base !== 2) begin
            n_fail++;
            $display("FAIL bp_count: words=%0d, required 2", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h04030201 || got_d[base+1] !== 32'h08070605) begin
                n_fail++;
                $display("FAIL bp_order: words=%h,%h, required 04030201,08070605", got_d[base], got_d[base+1]);
            end
        end
    endtask

    task automatic test_flush();
        int w;
        int base;
        base      = got_d.size();
        out_ready = 1'b1;
        send(IN_W'(24'h0000AA), 1'b0, w);
        send(IN_W'(24'h0000BB), 1'b0, w);
        pulse_flush();
        drain();
        n_cmp++;
        if (got_d.size() - base !== 1) begin
            n_fail++;
            $display("FAIL flush_count: words=%0d, required 1", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h0000BBAA || got_l[base] !== 2) begin
                n_fail++;
                $display("FAIL flush_partial: data=%h lanes=%0d, required 0000bbaa 2", got_d[base], got_l[base]);
            end
        end
        base = got_d.size();
        pulse_flush();
        repeat (5) tick();
        n_cmp++;
        if (got_d.size() - base !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: words=%0d valid=%b, required 0 0", got_d.size() - base, out_valid);
        end
    endtask

    task automatic test_flush_same_cycle();
        int w;
        int base;
        base      = got_d.size();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) send(IN_W'(i), 1'b0, w);
        send(IN_W'(4), 1'b1, w);
        drain();
        repeat (4) tick();
        n_cmp++;
        if (got_d.size() - base !== 1) begin
            n_fail++;
            $display("FAIL flush_same_count: words=%0d, required 1", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h04030201 || got_l[base] !== 4) begin
                n_fail++;
                $display("FAIL flush_same_word: data=%h lanes=%0d, required 04030201 4", got_d[base], got_l[base]);
            end
        end
    endtask

    task automatic test_flush_pending();
        int w;
        int base;
        base      = got_d.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(IN_W'(i), 1'b0, w);
        send(IN_W'(24'h000055), 1'b0, w);
        pulse_flush();
        tick();
`ifndef PACK_SAT_EN
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_in_ready: got %b with flush pending, required 0", in_ready);
        end
`endif
        n_cmp++;
        if (out_data !== 32'h04030201) begin
            n_fail++;
            $display("FAIL pend_hold: data=%h, required 04030201", out_data);
        end
        drain();
        n_cmp++;
        if (got_d.size() - base !== 2) begin
            n_fail++;
            $display("FAIL pend_count: words=%0d, required 2", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base+1] !== 32'h00000055 || got_l[base+1] !== 1) begin
                n_fail++;
                $display("FAIL pend_word: data=%h lanes=%0d, required 00000055 1", got_d[base+1], got_l[base+1]);
            end
        end
    endtask

    task automatic test_clear();
        int w;
        int base;
        out_ready = 1'b1;
        send(IN_W'(24'h000011), 1'b0, w);
        send(IN_W'(24'h000022), 1'b0, w);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_valid: got %b, required 0", out_valid);
        end
        base = got_d.size();
        for (int i = 1; i <= 4; i++) send(IN_W'(i), 1'b0, w);
        drain();
        n_cmp++;
        if (got_d.size() - base !== 1) begin
            n_fail++;
            $display("FAIL clear_restart_count: words=%0d, required 1", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h04030201) begin
                n_fail++;
                $display("FAIL clear_restart_word: data=%h, required 04030201", got_d[base]);
            end
        end
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) send(IN_W'(i), 1'b0, w);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre_valid: got %b, required 1", out_valid);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_held_valid: got %b, required 0", out_valid);
        end
        base      = got_d.size();
        out_ready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (got_d.size() - base !== 0) begin
            n_fail++;
            $display("FAIL clear_dropped: words=%0d, required 0", got_d.size() - base);
        end
    endtask

    task automatic test_async_reset();
        int w;
        int base;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(IN_W'(i), 1'b0, w);
        send(IN_W'(9), 1'b0, w);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre_valid: got %b, required 1", out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_valid: got %b, required 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0 || out_lanes !== '0) begin
            n_fail++;
            $display("FAIL areset_data: data=%h lanes=%0d, required 0 0", out_data, out_lanes);
        end
        tick();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        base      = got_d.size();
        repeat (6) tick();
        n_cmp++;
        if (got_d.size() - base !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_no_word: words=%0d valid=%b, required 0 0", got_d.size() - base, out_valid);
        end
    endtask

`ifdef PACK_SAT_EN
    task automatic test_saturate();
        int w;
        int base;
        base      = got_d.size();
        out_ready = 1'b1;
        cfg_shift = SHIFT_W'(4);
        send(IN_W'(24'h001230), 1'b0, w);
        n_cmp++;
        if (sat_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hit_clip: got %b, required 1", sat_hit);
        end
        send(IN_W'(24'hFFFF00), 1'b0, w);
        n_cmp++;
        if (sat_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hit_noclip: got %b, required 0", sat_hit);
        end
        send(IN_W'(24'h000050), 1'b0, w);
        pulse_flush();
        drain();
        cfg_shift = '0;
        n_cmp++;
        if (got_d.size() - base !== 1) begin
            n_fail++;
            $display("FAIL sat_count: words=%0d, required 1", got_d.size() - base);
        end else begin
            n_cmp++;
            if (got_d[base] !== 32'h0005F07F || got_l[base] !== 3) begin
                n_fail++;
                $display("FAIL sat_word: data=%h lanes=%0d, required 0005f07f 3", got_d[base], got_l[base]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int base;
        base = got_d.size();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = IN_W'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 299) == 0);
`ifdef PACK_SAT_EN
            cfg_shift = SHIFT_W'($urandom_range(0, 12));
`endif
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        clear    = 1'b0;
        drain();
        n_cmp++;
        if (got_d.size() - base < 100) begin
            n_fail++;
            $display("FAIL random_volume: words=%0d, required at least 100", got_d.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_back_to_back_backpressure();
        test_flush();
        test_flush_same_cycle();
        test_flush_pending();
        test_clear();
        test_async_reset();
`ifdef PACK_SAT_EN
        test_saturate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
